// File: rtl/writeback_unit_pkg.sv
// Shared constants for the writeback stage: load funct3 encodings, FSM state
// encoding and the zero word.
package writeback_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Combinational load data extraction: selects the addressed byte/halfword of a
// naturally aligned read word and sign- or zero-extends it.
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    byte_sel = rdata[7:0];
    half_sel = rdata[15:0];
    result   = rdata;

    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    if (addr_lo[1]) half_sel = rdata[31:16];

    // Word and reserved encodings fall through to the full word.
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RV32 writeback stage: drives the register-file write port, waits for load
// responses and counts retirements. Optional decode bypass via WB_BYPASS_EN.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      rf_rd,
  output logic            rf_wen,
  output logic [XLEN-1:0] rf_wdata,
`ifdef WB_BYPASS_EN
  output logic [31:0]     retire_cnt,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_pending,
  output logic [4:0]      pending_rd
`else
  output logic [31:0]     retire_cnt
`endif
);

  wb_state_e   state;
  logic [4:0]  lat_rd;
  logic        lat_wen;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic [31:0] load_data;

  assign in_ready = (state == ST_IDLE);

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .funct3  (lat_funct3),
    .addr_lo (lat_addr_lo),
    .result  (load_data)
  );

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lat_rd      <= 5'd0;
      lat_wen     <= 1'b0;
      lat_funct3  <= 3'd0;
      lat_addr_lo <= 2'd0;
      rf_rd       <= 5'd0;
      rf_wen      <= 1'b0;
      rf_wdata    <= ZERO_WORD;
      retire_cnt  <= ZERO_WORD;
    end else begin
      rf_wen <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              lat_rd      <= in_rd;
              lat_wen     <= in_wen & (in_rd != 5'd0);
              lat_funct3  <= in_funct3;
              lat_addr_lo <= in_addr_lo;
              state       <= ST_WAIT_LOAD;
            end else begin
              rf_rd      <= in_rd;
              rf_wdata   <= in_result;
              rf_wen     <= in_wen & (in_rd != 5'd0);
              retire_cnt <= retire_cnt + 32'd1;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (dmem_rvalid) begin
            rf_rd      <= lat_rd;
            rf_wdata   <= load_data;
            rf_wen     <= lat_wen;
            retire_cnt <= retire_cnt + 32'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // The register file returns the old value during a write, so decode takes
  // the in-flight value from here and stalls on an outstanding load.
  assign fwd_valid    = rf_wen;
  assign fwd_rd       = rf_rd;
  assign fwd_data     = rf_wdata;
  assign load_pending = (state == ST_WAIT_LOAD) & lat_wen;
  assign pending_rd   = lat_rd;
`endif

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RV32 core: accepts retiring instructions from the memory stage and produces the single write port of the 32×32 integer register file (`rd`, `reg_wen`, `data_in`). It waits for data-memory read responses on loads, extracts and sign- or zero-extends the addressed byte, halfword or word, and suppresses writes to x0. A retire counter and an optional forwarding/interlock port toward decode complete the block.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  memory stage presents a retiring instruction.
- `in_ready`  out  1  stage accepts it this cycle; the transfer happens when `in_valid & in_ready`.
- `in_rd`  in  5  destination register.
- `in_wen`  in  1  instruction writes `in_rd`.
- `in_is_load`  in  1  result comes from data memory.
- `in_funct3`  in  3  load size and sign encoding.
- `in_addr_lo`  in  2  low bits of the load address.
- `in_result`  in  32  ALU / PC+4 result for non-loads.
- `dmem_rvalid`  in  1  data-memory read response valid; single-cycle pulse.
- `dmem_rdata`  in  32  response word, naturally aligned.
- `rf_rd`  out  5  to register file `rd`.
- `rf_wen`  out  1  to register file `reg_wen`.
- `rf_wdata`  out  32  to register file `data_in`.
- `retire_cnt`  out  32  count of retired instructions; wraps.
- `fwd_valid`, `fwd_rd`, `fwd_data`, `load_pending`, `pending_rd`: present only with `WB_BYPASS_EN` (see Configuration).

## Operation
- States: IDLE and WAIT_LOAD. Reset state is IDLE.
- `in_ready = (state == IDLE)`.
- Non-load accepted in IDLE:
  - register `rd`, `in_result`;
  - `wen = in_wen & (in_rd != 0)`;
  - increment `retire_cnt`;
  - stay in IDLE.
- Load accepted in IDLE:
  - latch `rd`, `wen`, `funct3`, `addr_lo`;
  - go to WAIT_LOAD.
- WAIT_LOAD:
  - `dmem_rvalid` is sampled only in this state;
  - on `dmem_rvalid`, present the aligned/extended data, increment `retire_cnt`, and return to IDLE;
  - `dmem_rvalid` in IDLE is ignored.
- Load extraction by `in_funct3`:
  - 000 LB: byte `addr_lo`, sign-extended.
  - 100 LBU: byte `addr_lo`, zero-extended.
  - 001 LH: halfword `addr_lo[1]`, sign-extended.
  - 101 LHU: halfword `addr_lo[1]`, zero-extended.
  - 010 LW: full word.
  - Other encodings (011, 110, 111): full word.
  - For halfwords `addr_lo[0]` is ignored; for words `addr_lo` is ignored. Misalignment is not trapped here.
- Loads with `rd == 0` or `in_wen == 0` still wait for and consume their response, but do not write.
- Outputs are registered:
  - `rf_wen` is a one-cycle pulse;
  - `rf_rd` and `rf_wdata` hold their last value otherwise.

## Timing
- Reset values:
  - `rf_wen` = 0, `rf_rd` = 0, `rf_wdata` = 0;
  - `retire_cnt` = 0;
  - state = IDLE, so `in_ready` = 1;
  - `fwd_valid` = 0, `load_pending` = 0.
- Non-load accepted in cycle N: `rf_wen` is high in cycle N+1.
- Load accepted in cycle N, response in cycle M (M ≥ N+1):
  - `rf_wen` is high in cycle M+1;
  - `in_ready` is 0 during cycles N+1..M;
  - `in_ready` is 1 again in cycle M+1.
- Throughput:
  - one non-load per cycle;
  - each load costs at least one bubble.
- `retire_cnt` is updated in the same cycle as the corresponding `rf_wen` edge; it wraps from 0xFFFF_FFFF to 0.
- Reset asserted mid-load:
  - return to IDLE immediately, with no write;
  - a later stray `dmem_rvalid` is ignored.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwd_valid`, `fwd_rd`, `fwd_data` are combinational copies of `rf_wen`, `rf_rd`, `rf_wdata`. They let decode forward the value being written in the same cycle, since the register file reads the old value.
  - `load_pending = (state == WAIT_LOAD) & latched wen`, and `pending_rd` is the latched rd; decode uses these to interlock.
- `WB_BYPASS_EN` undefined: these ports and their logic are absent, and decode stalls conservatively.

## Structure
- Shared constant header holds:
  - the load `funct3` encodings (LB/LH/LW/LBU/LHU);
  - the state encoding;
  - the zero-word constant.
- Sub-module `load_align`: purely combinational; takes `rdata`, `funct3`, `addr_lo` and returns a 32-bit result.
- The FSM, output registers and counter live in `writeback_unit`.

## Test plan
- ADD result, rd=5, value 0x1234_5678 accepted in cycle N → cycle N+1: `rf_wen`=1, `rf_rd`=5, `rf_wdata`=0x1234_5678; `retire_cnt`=1.
- LB with `addr_lo`=3, rdata=0x80FF_0000, rvalid 3 cycles later → `rf_wdata`=0xFFFF_FF80; `in_ready`=0 while waiting.
- LHU with `addr_lo`=2, rdata=0xBEEF_1234 → 0x0000_BEEF; LH with `addr_lo`=0, rdata=0x0000_8001 → 0xFFFF_8001.
- ALU write with rd=0 → `rf_wen` stays 0 and `retire_cnt` still increments; LW with rd=0 consumes rvalid and `rf_wen` stays 0.
- Reset asserted while in WAIT_LOAD, then rvalid → no `rf_wen`, `in_ready`=1, all outputs 0.
- With `WB_BYPASS_EN`: LW rd=7 pending → `load_pending`=1, `pending_rd`=7; on write, `fwd_valid`=1, `fwd_rd`=7, `fwd_data` = written data.
